// File: rtl/sel_mux_rr_pkg.sv
// Shared definitions for the sel_mux_rr selector family: mode encodings,
// select-width helper and the legal channel-count range.
package sel_mux_rr_pkg;

   typedef enum logic {
      MODE_FIXED = 1'b0,
      MODE_RR    = 1'b1
   } mode_e;

   localparam int unsigned N_MIN = 2;
   localparam int unsigned N_MAX = 16;

   // Bits needed to index n items; never less than one so ports stay legal.
   function automatic int unsigned clog2_min1(input int unsigned n);
      int unsigned w;
      w = 0;
      for (int unsigned k = 0; k < 32; k++) begin
         if ((32'd1 << k) < n) begin
            w = k + 1;
         end
      end
      return (w == 0) ? 1 : w;
   endfunction

   function automatic bit n_in_range(input int unsigned n);
      return (n >= N_MIN) && (n <= N_MAX);
   endfunction

endpackage

// File: rtl/sel_mux_rr_rr_pick.sv
// Round-robin picker: first set bit of i_valid at or after i_start, wrapping.
// Rotate so i_start lands at bit 0, priority-encode, then rotate the index back.
module rr_pick
   import sel_mux_rr_pkg::*;
#(
   parameter  int unsigned N     = 4,
   localparam int unsigned SEL_W = clog2_min1(N)
) (
   input  logic [N-1:0]     i_valid,
   input  logic [SEL_W-1:0] i_start,
   output logic             o_found,
   output logic [SEL_W-1:0] o_idx
);

   logic [2*N-1:0]   w_dbl;
   logic [N-1:0]     w_rot;
   logic [SEL_W-1:0] w_off;
   logic [SEL_W:0]   w_sum;

   assign w_dbl = {i_valid, i_valid};
   assign w_rot = w_dbl[i_start +: N];

   always_comb begin
      o_found = 1'b0;
      w_off   = '0;
      for (int unsigned k = N; k > 0; k--) begin
         if (w_rot[k-1]) begin
            o_found = 1'b1;
            w_off   = SEL_W'(k - 1);
         end
      end
   end

   // i_start < N and w_off < N, so one conditional subtract is a full mod N.
   assign w_sum = {1'b0, i_start} + {1'b0, w_off};
   assign o_idx = (w_sum >= (SEL_W+1)'(N)) ? SEL_W'(w_sum - (SEL_W+1)'(N))
                                           : w_sum[SEL_W-1:0];

endmodule

// File: rtl/sel_mux_rr.sv
// N-way WIDTH-bit selector with valid/ready inputs, a registered output slot
// and runtime choice between fixed select and round-robin arbitration.
module sel_mux_rr
   import sel_mux_rr_pkg::*;
#(
   parameter  int unsigned WIDTH = 32,
   parameter  int unsigned N     = 4,
   localparam int unsigned SEL_W = clog2_min1(N)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N*WIDTH-1:0]   in_data,
   input  logic [N-1:0]         in_valid,
   output logic [N-1:0]         in_ready,
   input  logic                 rr_mode,
   input  logic [SEL_W-1:0]     sel,
   output logic [WIDTH-1:0]     out_data,
   output logic [SEL_W-1:0]     out_idx,
   output logic                 out_valid,
   input  logic                 out_ready
);

   if (!n_in_range(N)) begin : g_bad_n
      $error("sel_mux_rr: N=%0d outside legal range 2..16", N);
   end

   logic [WIDTH-1:0] r_out_data;
   logic [SEL_W-1:0] r_out_idx;
   logic             r_out_valid;
   logic [SEL_W-1:0] r_rr_ptr;

   logic             w_rr;
   logic             w_free;
   logic             w_fix_ok;
   logic             w_pick_found;
   logic [SEL_W-1:0] w_pick_idx;
   logic [SEL_W-1:0] w_cand;
   logic             w_cand_ok;
   logic [N-1:0]     w_grant;
   logic             w_take;
   logic [WIDTH-1:0] w_cand_data;
   logic [SEL_W-1:0] w_ptr_next;

   rr_pick #(.N(N)) u_pick (
      .i_valid (in_valid),
      .i_start (r_rr_ptr),
      .o_found (w_pick_found),
      .o_idx   (w_pick_idx)
   );

   assign w_rr   = (mode_e'(rr_mode) == MODE_RR);
   assign w_free = ~r_out_valid | out_ready;

   // Out-of-range sel matches no channel, so it yields no candidate.
   always_comb begin
      w_fix_ok = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         if (sel == SEL_W'(i)) begin
            w_fix_ok = in_valid[i];
         end
      end
   end

   assign w_cand    = w_rr ? w_pick_idx   : sel;
   assign w_cand_ok = w_rr ? w_pick_found : w_fix_ok;

   always_comb begin
      w_grant     = '0;
      w_cand_data = '0;
      for (int unsigned i = 0; i < N; i++) begin
         w_grant[i] = rst_n & w_free & w_cand_ok & (w_cand == SEL_W'(i));
         if (w_grant[i]) begin
            w_cand_data = in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   assign in_ready   = w_grant;
   assign w_take     = |w_grant;
   assign w_ptr_next = (w_cand == SEL_W'(N - 1)) ? '0 : w_cand + SEL_W'(1);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_out_data  <= '0;
         r_out_idx   <= '0;
         r_out_valid <= 1'b0;
         r_rr_ptr    <= '0;
      end else begin
         if (w_take) begin
            r_out_data  <= w_cand_data;
            r_out_idx   <= w_cand;
            r_out_valid <= 1'b1;
            if (w_rr) begin
               r_rr_ptr <= w_ptr_next;
            end
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign out_data  = r_out_data;
   assign out_idx   = r_out_idx;
   assign out_valid = r_out_valid;

endmodule

// File: tb/tb_sel_mux_rr.sv
// Directed bench for sel_mux_rr: a 4-channel instance checked through a
// scoreboard of expected words, plus a 3-channel instance for illegal select.
module tb_sel_mux_rr;

   localparam int unsigned W = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst_n;
   logic [4*W-1:0] in_data;
   logic [3:0]     in_valid;
   logic [3:0]     in_ready;
   logic           rr_mode;
   logic [1:0]     sel;
   logic [W-1:0]   out_data;
   logic [1:0]     out_idx;
   logic           out_valid;
   logic           out_ready;

   logic           rst_n_3;
   logic [3*W-1:0] in_data_3;
   logic [2:0]     in_valid_3;
   logic [2:0]     in_ready_3;
   logic           rr_mode_3;
   logic [1:0]     sel_3;
   logic [W-1:0]   out_data_3;
   logic [1:0]     out_idx_3;
   logic           out_valid_3;
   logic           out_ready_3;

   sel_mux_rr #(.WIDTH(W), .N(4)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .rr_mode   (rr_mode),
      .sel       (sel),
      .out_data  (out_data),
      .out_idx   (out_idx),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   sel_mux_rr #(.WIDTH(W), .N(3)) u_dut3 (
      .clk       (clk),
      .rst_n     (rst_n_3),
      .in_data   (in_data_3),
      .in_valid  (in_valid_3),
      .in_ready  (in_ready_3),
      .rr_mode   (rr_mode_3),
      .sel       (sel_3),
      .out_data  (out_data_3),
      .out_idx   (out_idx_3),
      .out_valid (out_valid_3),
      .out_ready (out_ready_3)
   );

   typedef struct packed {
      logic [W-1:0] data;
      logic [1:0]   idx;
   } word_t;

   typedef struct packed {
      logic       rst;
      logic       rr;
      logic [1:0] sel;
      logic [3:0] iv;
      logic       ordy;
      logic [3:0] erdy;
      logic       eov;
      logic       hold;
      logic       zero;
   } vec_t;

   word_t sb[$];
   word_t last_word;
   int    n_chk = 0;
   int    n_err = 0;
   vec_t  vt[31];

   function automatic logic [W-1:0] chdata(input int v, input int c);
      return {16'hCAFE, 8'(v), 8'(c)};
   endfunction

   function automatic logic [W-1:0] chdata3(input int s, input int c);
      return {16'hBEEF, 8'(s), 8'(c)};
   endfunction

   function automatic logic [1:0] onehot_idx(input logic [3:0] oh);
      logic [1:0] r;
      r = '0;
      for (int k = 0; k < 4; k++) begin
         if (oh[k]) r = 2'(k);
      end
      return r;
   endfunction

   function automatic vec_t mk(input logic rst, input logic rr, input logic [1:0] s,
                               input logic [3:0] iv, input logic ordy, input logic [3:0] erdy,
                               input logic eov, input logic hold, input logic zero);
      vec_t r;
      r.rst = rst; r.rr = rr; r.sel = s; r.iv = iv; r.ordy = ordy;
      r.erdy = erdy; r.eov = eov; r.hold = hold; r.zero = zero;
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every word the consumer takes must be the oldest expected one.
   always @(negedge clk) begin : mon
      word_t e;
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (sb.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL sb_unexpected: got idx %0d data 0x%08h, expected no word",
                     out_idx, out_data);
         end else begin
            e = sb.pop_front();
            chk("sb_data", 64'(out_data), 64'(e.data));
            chk("sb_idx", 64'(out_idx), 64'(e.idx));
         end
      end
   end

   task automatic drive3(input logic rst, input logic [1:0] s, input logic [2:0] iv,
                         input logic ordy, input int step);
      @(posedge clk);
      #1;
      rst_n_3     = rst;
      sel_3       = s;
      in_valid_3  = iv;
      out_ready_3 = ordy;
      for (int c = 0; c < 3; c++) in_data_3[c*W +: W] = chdata3(step, c);
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      word_t w;

      //          rst rr sel iv       ordy erdy     eov hold zero
      vt[0]  = mk(0, 1, 0, 4'b1111, 1, 4'b0000, 0, 0, 1);
      vt[1]  = mk(0, 1, 0, 4'b1111, 1, 4'b0000, 0, 0, 1);
      vt[2]  = mk(0, 1, 0, 4'b1111, 1, 4'b0000, 0, 0, 1);
      vt[3]  = mk(1, 1, 0, 4'b1111, 1, 4'b0001, 0, 0, 0);
      vt[4]  = mk(1, 1, 0, 4'b1111, 1, 4'b0010, 1, 0, 0);
      vt[5]  = mk(1, 1, 0, 4'b1111, 1, 4'b0100, 1, 0, 0);
      vt[6]  = mk(1, 1, 0, 4'b1111, 1, 4'b1000, 1, 0, 0);
      vt[7]  = mk(1, 1, 0, 4'b1111, 1, 4'b0001, 1, 0, 0);
      vt[8]  = mk(1, 1, 0, 4'b1111, 1, 4'b0010, 1, 0, 0);
      vt[9]  = mk(1, 1, 0, 4'b1111, 1, 4'b0100, 1, 0, 0);
      vt[10] = mk(1, 1, 0, 4'b1111, 1, 4'b1000, 1, 0, 0);
      vt[11] = mk(1, 0, 2, 4'b1111, 1, 4'b0100, 1, 0, 0);
      vt[12] = mk(1, 0, 3, 4'b1111, 1, 4'b1000, 1, 0, 0);
      vt[13] = mk(1, 0, 1, 4'b1111, 1, 4'b0010, 1, 0, 0);
      vt[14] = mk(1, 1, 0, 4'b1111, 1, 4'b0001, 1, 0, 0);
      vt[15] = mk(1, 1, 0, 4'b1000, 1, 4'b1000, 1, 0, 0);
      vt[16] = mk(1, 1, 0, 4'b1010, 1, 4'b0010, 1, 0, 0);
      vt[17] = mk(1, 1, 0, 4'b1010, 1, 4'b1000, 1, 0, 0);
      vt[18] = mk(1, 1, 0, 4'b1010, 1, 4'b0010, 1, 0, 0);
      vt[19] = mk(1, 1, 0, 4'b0010, 1, 4'b0010, 1, 0, 0);
      vt[20] = mk(1, 1, 0, 4'b1111, 0, 4'b0000, 1, 1, 0);
      vt[21] = mk(1, 1, 0, 4'b1111, 0, 4'b0000, 1, 1, 0);
      vt[22] = mk(1, 1, 0, 4'b1111, 0, 4'b0000, 1, 1, 0);
      vt[23] = mk(1, 1, 0, 4'b1111, 0, 4'b0000, 1, 1, 0);
      vt[24] = mk(1, 1, 0, 4'b1111, 1, 4'b0100, 1, 0, 0);
      vt[25] = mk(1, 1, 0, 4'b0000, 1, 4'b0000, 1, 0, 0);
      vt[26] = mk(1, 1, 0, 4'b0000, 1, 4'b0000, 0, 0, 0);
      vt[27] = mk(1, 1, 0, 4'b0100, 0, 4'b0100, 0, 0, 0);
      vt[28] = mk(1, 1, 0, 4'b0000, 0, 4'b0000, 1, 1, 0);
      vt[29] = mk(1, 1, 0, 4'b0000, 1, 4'b0000, 1, 0, 0);
      vt[30] = mk(1, 1, 0, 4'b0000, 1, 4'b0000, 0, 0, 0);

      rst_n     = 1'b0;
      rr_mode   = 1'b1;
      sel       = '0;
      in_valid  = 4'b1111;
      in_data   = '0;
      out_ready = 1'b1;
      last_word = '0;

      rst_n_3     = 1'b0;
      rr_mode_3   = 1'b0;
      sel_3       = '0;
      in_valid_3  = '0;
      in_data_3   = '0;
      out_ready_3 = 1'b0;

      for (int v = 0; v < 31; v++) begin
         @(posedge clk);
         #1;
         rst_n     = vt[v].rst;
         rr_mode   = vt[v].rr;
         sel       = vt[v].sel;
         in_valid  = vt[v].iv;
         out_ready = vt[v].ordy;
         for (int c = 0; c < 4; c++) in_data[c*W +: W] = chdata(v, c);
         @(negedge clk);
         chk($sformatf("v%0d_in_ready", v), 64'(in_ready), 64'(vt[v].erdy));
         chk($sformatf("v%0d_out_valid", v), 64'(out_valid), 64'(vt[v].eov));
         if (vt[v].hold) begin
            chk($sformatf("v%0d_hold_data", v), 64'(out_data), 64'(last_word.data));
            chk($sformatf("v%0d_hold_idx", v), 64'(out_idx), 64'(last_word.idx));
         end
         if (vt[v].zero) begin
            chk($sformatf("v%0d_rst_data", v), 64'(out_data), 64'(0));
            chk($sformatf("v%0d_rst_idx", v), 64'(out_idx), 64'(0));
         end
         if (vt[v].erdy != 4'b0000) begin
            w.idx  = onehot_idx(vt[v].erdy);
            w.data = chdata(v, int'(w.idx));
            sb.push_back(w);
            last_word = w;
         end
      end

      @(posedge clk);
      #1;
      in_valid = '0;
      @(negedge clk);
      chk("sb_left_over", 64'(sb.size()), 64'(0));

      drive3(1'b1, 2'd0, 3'b111, 1'b0, 1);
      chk("n3_s1_in_ready", 64'(in_ready_3), 64'(3'b001));
      chk("n3_s1_out_valid", 64'(out_valid_3), 64'(0));
      drive3(1'b1, 2'd3, 3'b111, 1'b0, 2);
      chk("n3_s2_in_ready", 64'(in_ready_3), 64'(3'b000));
      chk("n3_s2_out_valid", 64'(out_valid_3), 64'(1));
      chk("n3_s2_out_data", 64'(out_data_3), 64'(chdata3(1, 0)));
      chk("n3_s2_out_idx", 64'(out_idx_3), 64'(0));
      drive3(1'b1, 2'd3, 3'b111, 1'b1, 3);
      chk("n3_s3_in_ready", 64'(in_ready_3), 64'(3'b000));
      chk("n3_s3_out_valid", 64'(out_valid_3), 64'(1));
      drive3(1'b1, 2'd3, 3'b111, 1'b1, 4);
      chk("n3_s4_in_ready", 64'(in_ready_3), 64'(3'b000));
      chk("n3_s4_out_valid", 64'(out_valid_3), 64'(0));
      chk("n3_s4_out_data", 64'(out_data_3), 64'(chdata3(1, 0)));
      drive3(1'b1, 2'd1, 3'b111, 1'b0, 5);
      chk("n3_s5_in_ready", 64'(in_ready_3), 64'(3'b010));
      chk("n3_s5_out_valid", 64'(out_valid_3), 64'(0));
      drive3(1'b0, 2'd1, 3'b111, 1'b0, 6);
      chk("n3_s6_in_ready", 64'(in_ready_3), 64'(3'b000));
      chk("n3_s6_out_valid", 64'(out_valid_3), 64'(1));
      chk("n3_s6_out_data", 64'(out_data_3), 64'(chdata3(5, 1)));
      chk("n3_s6_out_idx", 64'(out_idx_3), 64'(1));
      drive3(1'b1, 2'd3, 3'b000, 1'b0, 7);
      chk("n3_s7_in_ready", 64'(in_ready_3), 64'(3'b000));
      chk("n3_s7_out_valid", 64'(out_valid_3), 64'(0));
      chk("n3_s7_out_data", 64'(out_data_3), 64'(0));
      chk("n3_s7_out_idx", 64'(out_idx_3), 64'(0));

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
